// File: rtl/breakout_game_ctrl.sv
// breakout_game_ctrl
//   Game sequencer for Breakout. Holds the brick-alive mask, lives and score,
//   and runs the IDLE/SERVE/PLAY/LOST/OVER/WIN state machine. Every state change
//   happens on the frame tick (i_animate & i_ani_stb). The one exception is
//   i_mode=0, which forces IDLE on any clock.
//
// Ports
//   i_clk, i_rst      clock; synchronous active-high reset
//   i_ani_stb         pixel strobe (enable)
//   i_animate         end-of-frame flag
//   i_mode            game enable; 0 forces IDLE
//   i_btn_lr          paddle buttons; any bit high requests launch
//   i_ball_lost       ball fell below the paddle line
//   i_brick_hit       per-brick overlap flags
//   o_brick_alive     1 = brick drawn and collidable
//   o_ball_run        ball motion enable (PLAY only)
//   o_ball_reset      1-cycle pulse: reload ball to the serve position
//   o_bounce_y        1-cycle pulse: reverse ball vertical direction
//   o_lives, o_score  lives remaining, saturating score
//   o_endgame, o_win  high in OVER/WIN, and in WIN only
//
// Configuration macro: BRICK_MULTI_HIT_EN
//   Defined:   every live brick hit on a tick clears, and each one scores.
//   Undefined: only the lowest-index live brick clears. The other hit bricks
//              stay alive and are evaluated again on the next tick.

module breakout_game_ctrl #(
  parameter int N_BRICKS      = 18,
  parameter int LIVES         = 3,
  parameter int SERVE_FRAMES  = 60,
  parameter int PTS_PER_BRICK = 1,
  parameter int SCORE_W       = 9
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_ani_stb,
  input  logic                i_animate,
  input  logic                i_mode,
  input  logic [1:0]          i_btn_lr,
  input  logic                i_ball_lost,
  input  logic [N_BRICKS-1:0] i_brick_hit,
  output logic [N_BRICKS-1:0] o_brick_alive,
  output logic                o_ball_run,
  output logic                o_ball_reset,
  output logic                o_bounce_y,
  output logic [1:0]          o_lives,
  output logic [SCORE_W-1:0]  o_score,
  output logic                o_endgame,
  output logic                o_win
);

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam int HCW   = $clog2(N_BRICKS + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [1:0]         LIVES_INI = 2'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_SERVE, S_PLAY, S_LOST, S_OVER, S_WIN
  } state_t;

  state_t              state_q, state_d;
  logic [N_BRICKS-1:0] alive_q, alive_d;
  logic [1:0]          lives_q, lives_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ball_reset_q, ball_reset_d;
  logic                bounce_q, bounce_d;

  logic                tick;
  logic [N_BRICKS-1:0] hit;
  logic [N_BRICKS-1:0] clr;
  logic [HCW-1:0]      n_clr;

  // Score plus n bricks worth of points. The sum is widened before the
  // compare so a large PTS_PER_BRICK cannot wrap back below SCORE_MAX.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [HCW-1:0]     n);
    logic [63:0] sum;
    sum = 64'(a) + 64'(n) * 64'(PTS_PER_BRICK);
    if (sum > 64'(SCORE_MAX)) return SCORE_MAX;
    return sum[SCORE_W-1:0];
  endfunction

`ifdef BRICK_MULTI_HIT_EN
  function automatic logic [HCW-1:0] popcount(input logic [N_BRICKS-1:0] v);
    logic [HCW-1:0] c;
    c = '0;
    for (int i = 0; i < N_BRICKS; i++) c = c + HCW'(v[i]);
    return c;
  endfunction
`endif

  always_comb begin
    tick = i_animate & i_ani_stb;
    hit  = i_brick_hit & alive_q;
`ifdef BRICK_MULTI_HIT_EN
    clr   = hit;
    n_clr = popcount(hit);
`else
    // Two's-complement trick: isolates the lowest set bit of hit.
    clr   = hit & (~hit + N_BRICKS'(1));
    n_clr = HCW'(1);
`endif

    state_d      = state_q;
    alive_d      = alive_q;
    lives_d      = lives_q;
    score_d      = score_q;
    cnt_d        = cnt_q;
    ball_reset_d = 1'b0;
    bounce_d     = 1'b0;

    if (!i_mode) begin
      state_d = S_IDLE;
      alive_d = '1;
      lives_d = LIVES_INI;
      score_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          alive_d = '1;
          lives_d = LIVES_INI;
          score_d = '0;
          cnt_d   = '0;
          if (tick) begin
            state_d      = S_SERVE;
            ball_reset_d = 1'b1;
          end
        end
        S_SERVE: begin
          if (tick) begin
            if ((|i_btn_lr) || (cnt_q == CNT_LAST)) begin
              state_d = S_PLAY;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_PLAY: begin
          if (tick) begin
            // A lost ball takes priority and masks any brick hits on the same tick.
            if (i_ball_lost) begin
              if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
              state_d = (lives_q <= 2'd1) ? S_OVER : S_LOST;
            end else if (|hit) begin
              alive_d  = alive_q & ~clr;
              score_d  = sat_add(score_q, n_clr);
              bounce_d = 1'b1;
              if ((alive_q & ~clr) == '0) state_d = S_WIN;
            end
          end
        end
        S_LOST: begin
          if (tick) begin
            state_d      = S_SERVE;
            cnt_d        = '0;
            ball_reset_d = 1'b1;
          end
        end
        S_OVER, S_WIN: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      alive_q      <= '1;
      lives_q      <= LIVES_INI;
      score_q      <= '0;
      cnt_q        <= '0;
      ball_reset_q <= 1'b0;
      bounce_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      alive_q      <= alive_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      cnt_q        <= cnt_d;
      ball_reset_q <= ball_reset_d;
      bounce_q     <= bounce_d;
    end
  end

  assign o_brick_alive = alive_q;
  assign o_ball_run    = (state_q == S_PLAY);
  assign o_ball_reset  = ball_reset_q;
  assign o_bounce_y    = bounce_q;
  assign o_lives       = lives_q;
  assign o_score       = score_q;
  assign o_endgame     = (state_q == S_OVER) || (state_q == S_WIN);
  assign o_win         = (state_q == S_WIN);

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Testbench for breakout_game_ctrl. A second instance with PTS_PER_BRICK=300
// shares all inputs and exercises score saturation.
module tb_breakout_game_ctrl;

  localparam logic [17:0] ALL = 18'h3FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        ani_stb, animate, mode, ball_lost;
  logic [1:0]  btn;
  logic [17:0] brick_hit;

  logic [17:0] alive, alive2;
  logic        run, run2, ball_reset, ball_reset2, bounce, bounce2;
  logic [1:0]  lives, lives2;
  logic [8:0]  score, score2;
  logic        endgame, endgame2, win, win2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  breakout_game_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(ani_stb), .i_animate(animate),
    .i_mode(mode), .i_btn_lr(btn), .i_ball_lost(ball_lost), .i_brick_hit(brick_hit),
    .o_brick_alive(alive), .o_ball_run(run), .o_ball_reset(ball_reset),
    .o_bounce_y(bounce), .o_lives(lives), .o_score(score),
    .o_endgame(endgame), .o_win(win)
  );

  breakout_game_ctrl #(.PTS_PER_BRICK(300)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_ani_stb(ani_stb), .i_animate(animate),
    .i_mode(mode), .i_btn_lr(btn), .i_ball_lost(ball_lost), .i_brick_hit(brick_hit),
    .o_brick_alive(alive2), .o_ball_run(run2), .o_ball_reset(ball_reset2),
    .o_bounce_y(bounce2), .o_lives(lives2), .o_score(score2),
    .o_endgame(endgame2), .o_win(win2)
  );

  typedef struct {
    logic        mode;
    logic [1:0]  btn;
    logic        lost;
    logic [17:0] hit;
    logic [17:0] e_alive;
    logic [1:0]  e_lives;
    logic [8:0]  e_score;
    logic        e_run, e_end, e_win, e_rst, e_bnc;
    logic [8:0]  e_score2;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic md, input logic [1:0] b, input logic l,
                              input logic [17:0] h, input logic [17:0] a,
                              input logic [1:0] lv, input logic [8:0] s,
                              input logic r, input logic e, input logic w,
                              input logic br, input logic bn, input logic [8:0] s2);
    vec_t v;
    v.mode = md; v.btn = b; v.lost = l; v.hit = h; v.e_alive = a; v.e_lives = lv;
    v.e_score = s; v.e_run = r; v.e_end = e; v.e_win = w; v.e_rst = br;
    v.e_bnc = bn; v.e_score2 = s2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One frame tick: drive the inputs with the tick, queue the expectation,
  // compare one clock later, then confirm that both pulses have dropped.
  task automatic apply(input vec_t v, input string nm);
    vec_t e;
    @(negedge clk);
    mode = v.mode; btn = v.btn; ball_lost = v.lost; brick_hit = v.hit;
    animate = 1'b1; ani_stb = 1'b1;
    sb_q.push_back(v);
    @(negedge clk);
    animate = 1'b0; ani_stb = 1'b0;
    e = sb_q.pop_front();
    chk({nm, ".alive"},   32'(alive),      32'(e.e_alive));
    chk({nm, ".lives"},   32'(lives),      32'(e.e_lives));
    chk({nm, ".score"},   32'(score),      32'(e.e_score));
    chk({nm, ".run"},     32'(run),        32'(e.e_run));
    chk({nm, ".endgame"}, 32'(endgame),    32'(e.e_end));
    chk({nm, ".win"},     32'(win),        32'(e.e_win));
    chk({nm, ".ball_rst"},32'(ball_reset), 32'(e.e_rst));
    chk({nm, ".bounce"},  32'(bounce),     32'(e.e_bnc));
    chk({nm, ".score2"},  32'(score2),     32'(e.e_score2));
    @(negedge clk);
    chk({nm, ".pulse_w"}, 32'({ball_reset, bounce}), 32'd0);
  endtask

  initial begin
    logic [17:0] a;
    logic [17:0] a2;

    // Vector table: brick hits, lost-ball priority, and running out of lives.
    a2 = 18'h3FFF9;
`ifdef BRICK_MULTI_HIT_EN
    tbl.push_back(mk(1, 0, 0, 18'h6, 18'h3FFF9, 3, 2, 1, 0, 0, 0, 1, 511));
    tbl.push_back(mk(1, 0, 0, 18'h6, 18'h3FFF9, 3, 2, 1, 0, 0, 0, 0, 511));
`else
    tbl.push_back(mk(1, 0, 0, 18'h6, 18'h3FFFD, 3, 1, 1, 0, 0, 0, 1, 300));
    tbl.push_back(mk(1, 0, 0, 18'h6, 18'h3FFF9, 3, 2, 1, 0, 0, 0, 1, 511));
`endif
    tbl.push_back(mk(1, 0, 1, 18'h1, a2, 2, 2, 0, 0, 0, 0, 0, 511)); // lost beats hit
    tbl.push_back(mk(1, 0, 0, 18'h0, a2, 2, 2, 0, 0, 0, 1, 0, 511)); // LOST -> SERVE
    tbl.push_back(mk(1, 1, 0, 18'h0, a2, 2, 2, 1, 0, 0, 0, 0, 511)); // button launch
    tbl.push_back(mk(1, 0, 0, 18'h2, a2, 2, 2, 1, 0, 0, 0, 0, 511)); // dead brick only
    tbl.push_back(mk(1, 0, 1, 18'h0, a2, 1, 2, 0, 0, 0, 0, 0, 511));
    tbl.push_back(mk(1, 0, 0, 18'h0, a2, 1, 2, 0, 0, 0, 1, 0, 511));
    tbl.push_back(mk(1, 2, 0, 18'h0, a2, 1, 2, 1, 0, 0, 0, 0, 511));
    tbl.push_back(mk(1, 0, 1, 18'h1, a2, 0, 2, 0, 1, 0, 0, 0, 511)); // last life -> OVER

    rst = 1'b1; ani_stb = 1'b0; animate = 1'b0; mode = 1'b0;
    ball_lost = 1'b0; btn = 2'b00; brick_hit = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.alive",    32'(alive),   32'(ALL));
    chk("reset.lives",    32'(lives),   32'd3);
    chk("reset.score",    32'(score),   32'd0);
    chk("reset.run",      32'(run),     32'd0);
    chk("reset.endgame",  32'(endgame), 32'd0);
    chk("reset.win",      32'(win),     32'd0);
    chk("reset.pulses",   32'({ball_reset, bounce}), 32'd0);

    // Serve, then auto-launch after SERVE_FRAMES ticks with no button.
    apply(mk(1, 0, 0, 0, ALL, 3, 0, 0, 0, 0, 1, 0, 0), "serve_entry");
    for (int i = 0; i < 60; i++)
      apply(mk(1, 0, 0, 0, ALL, 3, 0, (i == 59), 0, 0, 0, 0, 0), "serve_cnt");

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

    // OVER holds regardless of buttons, lost balls or hits.
    for (int i = 0; i < 100; i++)
      apply(mk(1, 3, 1, ALL, a2, 0, 2, 0, 1, 0, 0, 0, 511), "over_hold");

    // Dropping i_mode without a frame tick still returns to IDLE.
    @(negedge clk);
    mode = 1'b0; ball_lost = 1'b0; btn = 2'b00; brick_hit = '0;
    @(negedge clk);
    chk("mode0.endgame", 32'(endgame), 32'd0);
    chk("mode0.lives",   32'(lives),   32'd3);
    chk("mode0.alive",   32'(alive),   32'(ALL));
    chk("mode0.score",   32'(score),   32'd0);

    // Clear the whole wall.
    apply(mk(1, 0, 0, 0, ALL, 3, 0, 0, 0, 0, 1, 0, 0), "serve2");
    apply(mk(1, 1, 0, 0, ALL, 3, 0, 1, 0, 0, 0, 0, 0), "launch2");
`ifdef BRICK_MULTI_HIT_EN
    apply(mk(1, 0, 0, ALL, 18'h0, 3, 18, 0, 1, 1, 0, 1, 511), "clear_all");
`else
    for (int k = 1; k <= 18; k++) begin
      a = ALL << k;
      apply(mk(1, 0, 0, ALL, a, 3, 9'(k), (k < 18), (k == 18), (k == 18), 0, 1,
               (k == 1) ? 9'd300 : 9'd511), "clear_k");
    end
`endif
    apply(mk(1, 1, 1, ALL, 18'h0, 3, 18, 0, 1, 1, 0, 0, 511), "win_hold");
    apply(mk(0, 0, 0, 0, ALL, 3, 0, 0, 0, 0, 0, 0, 0), "win_to_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
